// File: rtl/multicycle_main_control.sv
// Main control FSM for a multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back and drives every datapath enable and mux select from the state.
module multicycle_main_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    state_t cur_state;
    state_t nxt_state;
    ctrl_t  ctrl_q;
    logic   dec_illegal;

    // Moore output decode; unlisted states (including unreachable codes) drive all zeros.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE: c.alu_src_b = 2'b11;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDIWB: c.reg_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection; opcode is only consulted in DECODE and MEMADR.
    always_comb begin
        nxt_state   = FETCH;
        dec_illegal = 1'b0;
        case (cur_state)
            FETCH:  nxt_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt_state = MEMADR;
                    OP_RTYPE:     nxt_state = EXEC;
                    OP_BEQ:       nxt_state = BRANCH;
                    OP_J:         nxt_state = JUMP;
                    OP_ADDI:      nxt_state = ADDIEX;
                    default: begin
                        nxt_state   = FETCH;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: nxt_state = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nxt_state = MEMWB;
            EXEC:   nxt_state = ALUWB;
            ADDIEX: nxt_state = ADDIWB;
            default: nxt_state = FETCH;
        endcase
    end

    // Outputs are registered alongside the state so they always match the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= FETCH;
            ctrl_q    <= ctrl_of(FETCH);
            illegal   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            ctrl_q    <= ctrl_of(nxt_state);
            if (dec_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    assign state       = cur_state;
    assign PCWrite     = ctrl_q.pc_write;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.i_or_d;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign IRWrite     = ctrl_q.ir_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUop       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: per-instruction state-sequence model plus
// per-state output table, checked every cycle, with literal pins on key values.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUop, PCSource;
    logic [3:0] state;
    logic       illegal;

    multicycle_main_control dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
        .PCSource(PCSource), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   checking = 1'b0;
    bit   model_ill = 1'b0;
    int   rw_cnt = 0, mw_cnt = 0, pcw_cnt = 0, pcwc_cnt = 0, irw_cnt = 0;
    logic [1:0] aluop_seen [16];
    logic [1:0] pcsrc_seen [16];

    wire [15:0] dut_v = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                         MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource};

    // Asserted outputs per state, straight from the state table.
    function automatic logic [15:0] spec_outputs(input int s);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            0:  begin mr = 1; irw = 1; pcw = 1; asb = 2'b01; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            9:  begin pcw = 1; psrc = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare process: one expected entry per cycle while checking.
    always @(negedge clk) begin
        exp_t e;
        if (checking) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("state", 32'(state), 32'(e.st));
                chk("illegal", 32'(illegal), 32'(e.ill));
                chk("outputs", 32'(dut_v), 32'(spec_outputs(int'(e.st))));
                rw_cnt   += int'(RegWrite);
                mw_cnt   += int'(MemWrite);
                pcw_cnt  += int'(PCWrite);
                pcwc_cnt += int'(PCWriteCond);
                irw_cnt  += int'(IRWrite);
                aluop_seen[state] = ALUop;
                pcsrc_seen[state] = PCSource;
            end
        end
    end

    // Expected state walk of one instruction, FETCH up to (not including) the next FETCH.
    task automatic load_seq(input logic [5:0] op, output int n);
        int  s[5];
        bit  bad;
        bad = 1'b0;
        s = '{0, 1, 0, 0, 0};
        case (op)
            6'b100011: begin s[2] = 2; s[3] = 3; s[4] = 4; n = 5; end
            6'b101011: begin s[2] = 2; s[3] = 5; n = 4; end
            6'b000000: begin s[2] = 6; s[3] = 7; n = 4; end
            6'b001000: begin s[2] = 10; s[3] = 11; n = 4; end
            6'b000100: begin s[2] = 8; n = 3; end
            6'b000010: begin s[2] = 9; n = 3; end
            default:   begin n = 2; bad = 1'b1; end
        endcase
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{st: 4'(s[i]), ill: model_ill});
        end
        if (bad) model_ill = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op);
        int n;
        opcode = op;
        load_seq(op, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'b000000;
        #12;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        chk("reset_outputs", 32'(dut_v), 32'h9410);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        checking = 1'b1;

        run_instr(6'b100011);   // lw
        run_instr(6'b000000);   // R-type
        run_instr(6'b000100);   // beq
        run_instr(6'b101011);   // sw
        run_instr(6'b000010);   // j
        run_instr(6'b001000);   // addi
        run_instr(6'b111111);   // unsupported
        run_instr(6'b100011);   // lw after illegal: flag must stay

        // Abort an lw in MEMRD with an asynchronous reset.
        opcode = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{st: 4'(i), ill: model_ill});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("memrd_iord", 32'(IorD), 32'd1);
        chk("pre_reset_illegal", 32'(illegal), 32'd1);
        checking = 1'b0;
        reset    = 1'b1;
        #1;
        chk("async_reset_state", 32'(state), 32'd0);
        chk("async_reset_illegal", 32'(illegal), 32'd0);
        chk("async_reset_outputs", 32'(dut_v), 32'h9410);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        model_ill = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        checking = 1'b1;

        run_instr(6'b000000);
        run_instr(6'b001000);
        checking = 1'b0;

        chk("aluop_exec", 32'(aluop_seen[6]), 32'h2);
        chk("aluop_branch", 32'(aluop_seen[8]), 32'h1);
        chk("pcsrc_branch", 32'(pcsrc_seen[8]), 32'h1);
        chk("pcsrc_jump", 32'(pcsrc_seen[9]), 32'h2);
        chk("regwrite_count", 32'(rw_cnt), 32'd6);
        chk("memwrite_count", 32'(mw_cnt), 32'd1);
        chk("pcwritecond_count", 32'(pcwc_cnt), 32'd1);
        chk("irwrite_count", 32'(irw_cnt), 32'd11);
        chk("pcwrite_count", 32'(pcw_cnt), 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
